// File: rtl/octal_sub_seq_ctrl.sv
// octal_sub_seq_ctrl: digit-serial four-digit octal subtractor with optional magnitude pass
module octal_sub_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        cin,
    input  logic        abs_mode,
    output logic        busy,
    output logic        done,
    output logic [11:0] d,
    output logic        bout,
    output logic        neg
);
    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        borrow_q, borrow_d, abs_q, abs_d, bout_q, bout_d, neg_q, neg_d;
    logic [11:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic [3:0]  sh, sub_r, neg_r;
    logic [2:0]  a_dig, b_dig, d_dig, dig;
    logic [11:0] d_ins;
    // current digit slice, both digit subtractors and the merged d with digit idx replaced
    always_comb begin
        sh    = {1'b0, idx_q, 1'b0} + {2'b00, idx_q};
        a_dig = 3'(a_q >> sh);
        b_dig = 3'(b_q >> sh);
        d_dig = 3'(d_q >> sh);
        sub_r = {1'b0, a_dig} - {1'b0, b_dig} - {3'b000, borrow_q};
        neg_r = 4'd0 - {1'b0, d_dig} - {3'b000, borrow_q};
        dig   = (state_q == SUB) ? sub_r[2:0] : neg_r[2:0];
        d_ins = (d_q & ~(12'h007 << sh)) | ({9'd0, dig} << sh);
    end
    // next-state logic: operand capture, one digit per cycle, optional negate pass
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        abs_d    = abs_q;
        bout_d   = bout_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        case (state_q)
            IDLE: if (start) begin
                a_d      = a;
                b_d      = b;
                abs_d    = abs_mode;
                borrow_d = cin;
                idx_d    = 2'd0;
                d_d      = 12'd0;
                bout_d   = 1'b0;
                neg_d    = 1'b0;
                state_d  = SUB;
            end
            SUB: begin
                d_d      = d_ins;
                borrow_d = sub_r[3];
                idx_d    = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    bout_d   = sub_r[3];
                    borrow_d = 1'b0;
                    state_d  = (abs_q && sub_r[3]) ? NEG : DONE;
                end
            end
            NEG: begin
                d_d      = d_ins;
                borrow_d = neg_r[3];
                idx_d    = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    neg_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            borrow_q <= 1'b0;
            abs_q    <= 1'b0;
            bout_q   <= 1'b0;
            neg_q    <= 1'b0;
            a_q      <= 12'd0;
            b_q      <= 12'd0;
            d_q      <= 12'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            abs_q    <= abs_d;
            bout_q   <= bout_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
        end
    end
    assign busy = (state_q == SUB) || (state_q == NEG);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;
    assign neg  = neg_q;
endmodule

// File: tb/tb_octal_sub_seq_ctrl.sv
// tb_octal_sub_seq_ctrl: scoreboard bench for the octal subtractor sequencer
module tb_octal_sub_seq_ctrl;
    logic        clk = 0, rst = 1, start = 0, cin = 0, abs_mode = 0;
    logic [11:0] a = 0, b = 0;
    logic        busy, done, bout, neg;
    logic [11:0] d;
    int          cyc = 0, total = 0, bad = 0, bcnt = 0;

    typedef struct {
        logic [11:0] d;
        logic        bout;
        logic        neg;
        int          lat;
        int          t0;
    } exp_t;
    exp_t q[$];

    octal_sub_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .abs_mode(abs_mode), .busy(busy), .done(done), .d(d), .bout(bout), .neg(neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [11:0] ta, input logic [11:0] tb, input logic tc, input logic tab);
        exp_t r;
        int dif = int'(ta) - int'(tb) - int'(tc);
        r.bout = dif < 0;
        r.neg  = tab && dif < 0;
        r.d    = r.neg ? 12'(-dif) : 12'(dif);
        r.lat  = r.neg ? 9 : 5;
        r.t0   = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) bcnt++;
        if (done === 1'b1) begin
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("d", d, e.d);
                chk("bout", bout, e.bout);
                chk("neg", neg, e.neg);
                chk("latency", cyc - e.t0, e.lat);
                chk("busy_cycles", bcnt, e.lat - 1);
            end
            bcnt = 0;
        end else if (busy !== 1'b1) bcnt = 0;
    end

    task automatic op(input logic [11:0] ta, input logic [11:0] tb, input logic tc, input logic tab,
                      input exp_t e, input bit inj);
        int k = 0;
        @(negedge clk);
        e.t0 = cyc;
        q.push_back(e);
        a = ta; b = tb; cin = tc; abs_mode = tab; start = 1;
        do begin
            @(negedge clk);
            k++;
            start = inj && (k == 2 || k == 5);
            if (start) begin
                a = 12'($urandom); b = 12'($urandom);
                cin = 1'($urandom); abs_mode = 1'($urandom);
            end
        end while (done !== 1'b1 && k < 20);
        chk("done_seen", done, 1);
        @(negedge clk);
        start = 0;
        chk("hold_d", d, e.d);
        chk("hold_bout", bout, e.bout);
        chk("hold_neg", neg, e.neg);
    endtask

    function automatic exp_t mk(input logic [11:0] ed, input logic eb, input logic en);
        exp_t r;
        r.d = ed; r.bout = eb; r.neg = en; r.lat = en ? 9 : 5; r.t0 = 0;
        return r;
    endfunction

    initial begin
        logic [11:0] ra, rb;
        logic        rc, rab;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_d", d, 0);
        chk("rst_bout", bout, 0);
        chk("rst_neg", neg, 0);
        rst = 0;
        op(12'o1234, 12'o0123, 0, 0, mk(12'o1111, 0, 0), 0);
        op(12'o0100, 12'o0001, 0, 0, mk(12'o0077, 0, 0), 0);
        op(12'o0005, 12'o0007, 0, 0, mk(12'o7776, 1, 0), 0);
        op(12'o0005, 12'o0007, 0, 1, mk(12'o0002, 1, 1), 0);
        op(12'o0000, 12'o0000, 1, 1, mk(12'o0001, 1, 1), 0);
        op(12'o0000, 12'o0000, 0, 1, mk(12'o0000, 0, 0), 0);
        op(12'o1234, 12'o0123, 0, 0, mk(12'o1111, 0, 0), 1);
        op(12'o0005, 12'o0007, 0, 1, mk(12'o0002, 1, 1), 1);
        @(negedge clk);
        a = 12'o7654; b = 12'o0123; cin = 0; abs_mode = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_d", d, 0);
        chk("abort_bout", bout, 0);
        chk("abort_neg", neg, 0);
        op(12'o0005, 12'o0007, 0, 1, mk(12'o0002, 1, 1), 0);
        for (int i = 0; i < 150; i++) begin
            ra = 12'($urandom); rb = 12'($urandom);
            rc = 1'($urandom); rab = 1'($urandom);
            op(ra, rb, rc, rab, model(ra, rb, rc, rab), ($urandom_range(0, 3) == 0));
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
